coin_accumulator: RTL
=====================

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 SHALL have parameter MAX_TOTAL, default 100, the maximum credit in rupees.
REQ-002 SHALL have parameter START_CYCLES, default 3, the number of clock cycles start is held high.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, the idle cycles in COLLECT before auto-refund.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port coin_valid, input, 1 bit: one-cycle strobe, one coin inserted.
REQ-007 SHALL have port coin_type, input, 2 bits: 00=Rs1, 01=Rs2, 10=Rs5, 11=Rs10; valid with coin_valid.
REQ-008 SHALL have port buy, input, 1 bit: one-cycle request to commit the credit to the vending machine.
REQ-009 SHALL have port cancel, input, 1 bit: one-cycle request to abort and refund.
REQ-010 SHALL have port credit, output, 7 bits: running accumulated credit, for display.
REQ-011 SHALL have port total_coins, output, 7 bits: committed amount to the vending machine, nonzero only in PRESENT.
REQ-012 SHALL have port start, output, 1 bit: transaction start to the vending machine.
REQ-013 SHALL have port coin_reject, output, 1 bit: one-cycle pulse, coin returned unaccepted.
REQ-014 SHALL have port refund_valid, output, 1 bit: one-cycle pulse, refund_amount valid.
REQ-015 SHALL have port refund_amount, output, 7 bits: refunded rupees, 0 when refund_valid is low.
REQ-016 SHALL have port acc_state, output, 2 bits: current state encoding.

Function
REQ-017 SHALL implement states IDLE=0, COLLECT=1, PRESENT=2, CLEAR=3; all outputs registered.
REQ-018 In IDLE or COLLECT, SHALL register an accepted coin so credit = credit + value on the next edge, and SHALL enter or remain in COLLECT.
REQ-019 SHALL reject a coin when credit + value > MAX_TOTAL; the sum is computed 8 bits wide, coin_reject pulses on the next cycle, and credit is unchanged.
REQ-020 In COLLECT, buy with post-coin credit > 0 SHALL move to PRESENT; buy with credit 0 SHALL be ignored.
REQ-021 In COLLECT, cancel SHALL pulse refund_valid with refund_amount = credit, clear credit, and return to IDLE.
REQ-022 When cancel and coin arrive in the same cycle, SHALL reject the coin and refund only the prior credit; cancel SHALL win over buy.
REQ-023 When coin and buy arrive in the same cycle, SHALL include the coin if accepted and present the updated sum.
REQ-024 In PRESENT, SHALL drive start=1 and total_coins=credit, stable, for exactly START_CYCLES cycles, then go to CLEAR.
REQ-025 In PRESENT, SHALL reject all coins and ignore buy and cancel.
REQ-026 In CLEAR, SHALL drive start=0, total_coins=0, and credit=0 for one cycle, then go to IDLE.
REQ-027 In IDLE, cancel and buy SHALL be ignored; no refund pulse SHALL be produced.

Reset
REQ-028 While reset=0, SHALL immediately force state IDLE and all outputs, counters, and credit to 0; credit lost mid-transaction SHALL NOT be refunded.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Configuration
REQ-030 With COIN_TIMEOUT_EN defined, a COLLECT inactivity counter SHALL be included; it is cleared by any accepted coin, and on reaching TIMEOUT_CYCLES it SHALL trigger a refund identical to cancel and return to IDLE.
REQ-031 With COIN_TIMEOUT_EN undefined, no counter logic SHALL exist and COLLECT SHALL persist indefinitely.

Structure
REQ-032 Shared package coin_pkg SHALL hold the state enum, coin value constants (1/2/5/10), and the coin_type encoding.
REQ-033 Sub-module coin_decoder SHALL be combinational, mapping coin_type to a 7-bit value.

Verification
REQ-034 Six Rs10 coins then buy -> credit=60; start=1 and total_coins=60 for 3 cycles; then CLEAR with total_coins=0; then IDLE.
REQ-035 Credit 95, insert Rs10 -> coin_reject pulses once and credit stays 95; insert Rs5 -> credit=100.
REQ-036 Rs5+Rs2 then cancel -> refund_valid for 1 cycle, refund_amount=7, credit=0, IDLE.
REQ-037 buy with credit 0 in IDLE -> start stays 0 and state stays IDLE.
REQ-038 With COIN_TIMEOUT_EN and TIMEOUT_CYCLES=20, Rs5 then idle 20 cycles -> refund_amount=5; without the macro -> no refund after 100 cycles.
REQ-039 reset=0 asserted in the 2nd PRESENT cycle -> start=0, total_coins=0, credit=0 immediately, no refund_valid.

Source files
------------

// File: rtl/coin_accumulator_pkg.sv
// Shared definitions for the coin accumulator: FSM state encoding,
// coin_type encoding and coin face values in rupees.
package coin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2,
    ST_CLEAR   = 2'd3
  } acc_state_e;

  typedef enum logic [1:0] {
    COIN_RS1  = 2'b00,
    COIN_RS2  = 2'b01,
    COIN_RS5  = 2'b10,
    COIN_RS10 = 2'b11
  } coin_type_e;

  localparam int CREDIT_W = 7;

  localparam logic [CREDIT_W-1:0] COIN_VAL_RS1  = 7'd1;
  localparam logic [CREDIT_W-1:0] COIN_VAL_RS2  = 7'd2;
  localparam logic [CREDIT_W-1:0] COIN_VAL_RS5  = 7'd5;
  localparam logic [CREDIT_W-1:0] COIN_VAL_RS10 = 7'd10;

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin accumulator front/back bundle: coin/buy/cancel requests in,
// credit display, vending-machine commit and refund results out.
interface coin_accumulator_if;

  logic       coin_valid;
  logic [1:0] coin_type;
  logic       buy;
  logic       cancel;
  logic [6:0] credit;
  logic [6:0] total_coins;
  logic       start;
  logic       coin_reject;
  logic       refund_valid;
  logic [6:0] refund_amount;
  logic [1:0] acc_state;

  modport master (
    output coin_valid, coin_type, buy, cancel,
    input  credit, total_coins, start, coin_reject,
    input  refund_valid, refund_amount, acc_state
  );

  modport slave (
    input  coin_valid, coin_type, buy, cancel,
    output credit, total_coins, start, coin_reject,
    output refund_valid, refund_amount, acc_state
  );

endinterface

// File: rtl/coin_accumulator_decoder.sv
// Combinational coin_type -> rupee value lookup.
module coin_decoder
  import coin_pkg::*;
(
  input  logic [1:0] coin_type,
  output logic [6:0] coin_value
);

  // Map the two-bit coin code onto its face value.
  always_comb begin
    coin_value = COIN_VAL_RS1;
    case (coin_type)
      COIN_RS1:  coin_value = COIN_VAL_RS1;
      COIN_RS2:  coin_value = COIN_VAL_RS2;
      COIN_RS5:  coin_value = COIN_VAL_RS5;
      COIN_RS10: coin_value = COIN_VAL_RS10;
      default:   coin_value = COIN_VAL_RS1;
    endcase
  end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins into a credit, commits it to the vending
// machine on buy, refunds it on cancel. All outputs are registered.
// Optional build macro COIN_TIMEOUT_EN adds a COLLECT inactivity timer that
// refunds the credit after TIMEOUT_CYCLES cycles without an accepted coin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no credit, waiting for the first coin
// COLLECT | credit building up; buy commits, cancel refunds
// PRESENT | start=1, total_coins=credit held for START_CYCLES cycles
// CLEAR   | one cycle with everything zeroed, then back to IDLE
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int MAX_TOTAL      = 100,
  parameter int START_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  coin_accumulator_if.slave bus
);

  localparam int                 PW     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [PW-1:0]      PRES_LOAD = PW'(START_CYCLES - 1);
  localparam logic [CREDIT_W:0]  MAX_SUM   = (CREDIT_W+1)'(MAX_TOTAL);

  acc_state_e            state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   total_coins_q, total_coins_d;
  logic                  start_q, start_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  refund_valid_q, refund_valid_d;
  logic [CREDIT_W-1:0]   refund_amount_q, refund_amount_d;
  logic [PW-1:0]         pres_cnt_q, pres_cnt_d;

  logic [CREDIT_W-1:0]   coin_value;
  logic [CREDIT_W:0]     coin_sum;
  logic                  can_collect;
  logic                  cancel_hit;
  logic                  coin_ok;
  logic                  timeout_hit;
  logic                  refund_hit;
  logic [CREDIT_W-1:0]   credit_nxt;

  coin_decoder u_decoder (
    .coin_type  (bus.coin_type),
    .coin_value (coin_value)
  );

  // Coin acceptance and credit arithmetic; the 8-bit sum catches carry past 127.
  always_comb begin
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
    can_collect = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    cancel_hit  = (state_q == ST_COLLECT) && bus.cancel;
    coin_ok     = bus.coin_valid && can_collect && !cancel_hit && (coin_sum <= MAX_SUM);
    credit_nxt  = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    refund_hit  = cancel_hit || timeout_hit;
  end

`ifdef COIN_TIMEOUT_EN
  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Inactivity timer: reloaded by each accepted coin, counts down in COLLECT.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    timeout_hit = (state_q == ST_COLLECT) && !coin_ok && (tmo_cnt_q == '0);
    if (coin_ok) begin
      tmo_cnt_d = TMO_LOAD;
    end else if ((state_q == ST_COLLECT) && (tmo_cnt_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q - TW'(1);
    end
  end

  // Inactivity timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // No timer in this build; COLLECT waits for buy or cancel forever.
  // TIMEOUT_CYCLES is folded in only so the parameter stays referenced.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES < 0);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel/timeout take priority over buy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (refund_hit) begin
          state_d = ST_IDLE;
        end else if (bus.buy && (credit_nxt != '0)) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (pres_cnt_q == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values, registered below so every output is a flop.
  always_comb begin
    credit_d        = credit_nxt;
    total_coins_d   = '0;
    start_d         = 1'b0;
    coin_reject_d   = bus.coin_valid && !coin_ok;
    refund_valid_d  = refund_hit;
    refund_amount_d = refund_hit ? credit_q : '0;
    pres_cnt_d      = pres_cnt_q;

    if (refund_hit || (state_d == ST_CLEAR)) begin
      credit_d = '0;
    end

    if (state_d == ST_PRESENT) begin
      start_d       = 1'b1;
      total_coins_d = credit_nxt;
    end

    if ((state_q != ST_PRESENT) && (state_d == ST_PRESENT)) begin
      pres_cnt_d = PRES_LOAD;
    end else if ((state_q == ST_PRESENT) && (pres_cnt_q != '0)) begin
      pres_cnt_d = pres_cnt_q - PW'(1);
    end
  end

  // Output and datapath registers; reset drops credit without refunding it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q        <= '0;
      total_coins_q   <= '0;
      start_q         <= 1'b0;
      coin_reject_q   <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      pres_cnt_q      <= '0;
    end else begin
      credit_q        <= credit_d;
      total_coins_q   <= total_coins_d;
      start_q         <= start_d;
      coin_reject_q   <= coin_reject_d;
      refund_valid_q  <= refund_valid_d;
      refund_amount_q <= refund_amount_d;
      pres_cnt_q      <= pres_cnt_d;
    end
  end

  assign bus.credit        = credit_q;
  assign bus.total_coins   = total_coins_q;
  assign bus.start         = start_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.refund_valid  = refund_valid_q;
  assign bus.refund_amount = refund_amount_q;
  assign bus.acc_state     = state_q;

endmodule
